// File: rtl/decode_pkg.sv
// Shared RV32 decode constants: opcodes, format codes, funct3/funct7 values.
package decode_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

endpackage

// File: rtl/decode_if.sv
// Instruction input bus: the fetch side drives, the decoder consumes.
interface decode_if;
    import decode_pkg::*;

    logic [XLEN-1:0] instr;
    logic            instr_valid;

    modport master (output instr, output instr_valid);
    modport slave  (input  instr, input  instr_valid);
endinterface

// File: rtl/decode_imm_gen.sv
// Builds the sign-extended immediate for the decoded instruction format.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:7]     instr,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm_ext
);

    // Immediate bit scatter per format; R and NONE carry no immediate.
    always_comb begin
        imm_ext = '0;
        case (fmt)
            FMT_I: imm_ext = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm_ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            FMT_U: imm_ext = {instr[31:12], 12'b0};
            FMT_J: imm_ext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// RV32I(M) field decoder with combinational slices and a registered capture stage.
module decode
    import decode_pkg::*;
#(
    parameter bit EN_RV32M = 1'b0
)
(
    input  logic            clk,
    input  logic            reset,
    decode_if.slave         bus,
    output logic [6:0]      funct7,
    output logic [4:0]      rs2,
    output logic [4:0]      rs1,
    output logic [2:0]      funct3,
    output logic [4:0]      rd,
    output logic [6:0]      opcode,
    output logic [11:0]     imm_i,
    output logic [19:0]     imm_u,
    output logic [XLEN-1:0] imm_ext,
    output logic [2:0]      fmt,
    output logic            illegal,
    output logic            valid_q,
    output logic [2:0]      fmt_q,
    output logic [XLEN-1:0] imm_ext_q,
    output logic [4:0]      rd_q,
    output logic [4:0]      rs1_q,
    output logic [4:0]      rs2_q,
    output logic            illegal_q
);

    fmt_e fmt_c;
    logic r_f7_ok;
    logic sh_f7_ok;

    // Raw field slices; unknown bits flow straight through.
    assign funct7 = bus.instr[31:25];
    assign rs2    = bus.instr[24:20];
    assign rs1    = bus.instr[19:15];
    assign funct3 = bus.instr[14:12];
    assign rd     = bus.instr[11:7];
    assign opcode = bus.instr[6:0];
    assign imm_i  = bus.instr[31:20];
    assign imm_u  = bus.instr[31:12];
    assign fmt    = fmt_c;

    // Format selection from the major opcode.
    always_comb begin
        fmt_c = FMT_NONE;
        case (opcode)
            OP_OP:                                   fmt_c = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR,
            OP_SYSTEM, OP_MISC_MEM:                  fmt_c = FMT_I;
            OP_STORE:                                fmt_c = FMT_S;
            OP_BRANCH:                               fmt_c = FMT_B;
            OP_LUI, OP_AUIPC:                        fmt_c = FMT_U;
            OP_JAL:                                  fmt_c = FMT_J;
            default:                                 fmt_c = FMT_NONE;
        endcase
    end

    assign sh_f7_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
    assign r_f7_ok  = sh_f7_ok || (EN_RV32M && (funct7 == F7_MULDIV));

    // Legality: compressed/unknown opcodes, undefined funct3, bad funct7.
    always_comb begin
        illegal = 1'b0;
        if ((bus.instr[1:0] != 2'b11) || (fmt_c == FMT_NONE)) begin
            illegal = 1'b1;
        end
        case (opcode)
            OP_OP:       if (!r_f7_ok) illegal = 1'b1;
            OP_IMM:      if (((funct3 == F3_SLL) || (funct3 == F3_SR)) && !sh_f7_ok)
                             illegal = 1'b1;
            OP_LOAD:     if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111))
                             illegal = 1'b1;
            OP_STORE:    if (funct3[2] || (funct3 == 3'b011)) illegal = 1'b1;
            OP_BRANCH:   if ((funct3 == 3'b010) || (funct3 == 3'b011)) illegal = 1'b1;
            OP_JALR:     if (funct3 != 3'b000) illegal = 1'b1;
            OP_SYSTEM:   if (funct3 == 3'b100) illegal = 1'b1;
            OP_MISC_MEM: if (funct3[2:1] != 2'b00) illegal = 1'b1;
            default: ;
        endcase
    end

    imm_gen u_imm_gen (
        .instr   (bus.instr[31:7]),
        .fmt     (fmt_c),
        .imm_ext (imm_ext)
    );

    // Capture stage: valid_q tracks every cycle, data only on instr_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            fmt_q     <= 3'd0;
            imm_ext_q <= '0;
            rd_q      <= 5'd0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= bus.instr_valid;
            if (bus.instr_valid) begin
                fmt_q     <= fmt_c;
                imm_ext_q <= imm_ext;
                rd_q      <= rd;
                rs1_q     <= rs1;
                rs2_q     <= rs2;
                illegal_q <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: slice walk, format/immediate/legality vectors, capture stage.
module tb_decode;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  funct7;
    logic [4:0]  rs2, rs1, rd, rd_q, rs1_q, rs2_q;
    logic [2:0]  funct3, fmt, fmt_q;
    logic [6:0]  opcode;
    logic [11:0] imm_i;
    logic [19:0] imm_u;
    logic [31:0] imm_ext, imm_ext_q;
    logic        illegal, valid_q, illegal_q;

    int tests = 0;
    int fails = 0;

    decode_if bus ();

    decode #(.EN_RV32M(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .funct7    (funct7),
        .rs2       (rs2),
        .rs1       (rs1),
        .funct3    (funct3),
        .rd        (rd),
        .opcode    (opcode),
        .imm_i     (imm_i),
        .imm_u     (imm_u),
        .imm_ext   (imm_ext),
        .fmt       (fmt),
        .illegal   (illegal),
        .valid_q   (valid_q),
        .fmt_q     (fmt_q),
        .imm_ext_q (imm_ext_q),
        .rd_q      (rd_q),
        .rs1_q     (rs1_q),
        .rs2_q     (rs2_q),
        .illegal_q (illegal_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-hot expectation for a field spanning instr[hi:lo] when bit k is set.
    function automatic logic [31:0] onehot_exp(input int k, input int lo, input int hi);
        logic [31:0] r;
        r = 32'd0;
        if (k >= lo && k <= hi) r[k - lo] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_q(input string tag, input logic v, input logic [2:0] f,
                         input logic [31:0] im, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic il);
        chk({tag, ".valid_q"},   32'(valid_q),   32'(v));
        chk({tag, ".fmt_q"},     32'(fmt_q),     32'(f));
        chk({tag, ".imm_ext_q"}, imm_ext_q,      im);
        chk({tag, ".rd_q"},      32'(rd_q),      32'(d));
        chk({tag, ".rs1_q"},     32'(rs1_q),     32'(s1));
        chk({tag, ".rs2_q"},     32'(rs2_q),     32'(s2));
        chk({tag, ".illegal_q"}, 32'(illegal_q), 32'(il));
    endtask

    task automatic chk_dec(input string tag, input logic [31:0] word, input logic [2:0] f,
                           input logic [31:0] im, input logic il);
        bus.instr = word;
        #10;
        chk({tag, ".fmt"},     32'(fmt),     32'(f));
        chk({tag, ".imm_ext"}, imm_ext,      im);
        chk({tag, ".illegal"}, 32'(illegal), 32'(il));
    endtask

    initial begin
        reset           = 1'b1;
        bus.instr       = 32'd0;
        bus.instr_valid = 1'b0;
        tick();
        tick();
        chk_q("reset", 1'b0, 3'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);

        // One-hot walk across all instruction bits, reset still asserted.
        for (int k = 0; k < 32; k++) begin
            bus.instr = 32'd0;
            bus.instr[k] = 1'b1;
            #10;
            chk($sformatf("walk%0d.funct7", k), 32'(funct7), onehot_exp(k, 25, 31));
            chk($sformatf("walk%0d.rs2", k),    32'(rs2),    onehot_exp(k, 20, 24));
            chk($sformatf("walk%0d.rs1", k),    32'(rs1),    onehot_exp(k, 15, 19));
            chk($sformatf("walk%0d.funct3", k), 32'(funct3), onehot_exp(k, 12, 14));
            chk($sformatf("walk%0d.rd", k),     32'(rd),     onehot_exp(k, 7, 11));
            chk($sformatf("walk%0d.opcode", k), 32'(opcode), onehot_exp(k, 0, 6));
            chk($sformatf("walk%0d.imm_i", k),  32'(imm_i),  onehot_exp(k, 20, 31));
            chk($sformatf("walk%0d.imm_u", k),  32'(imm_u),  onehot_exp(k, 12, 31));
        end

        // Unknown bits pass through untouched.
        bus.instr = 32'h0000_0000;
        bus.instr[24:20] = 5'bxxxxx;
        #10;
        chk("xprop.rs2", 32'(rs2), {27'd0, 5'bxxxxx});
        chk("xprop.rs1", 32'(rs1), 32'd0);

        // addi x1, x0, 10
        bus.instr = 32'h00A0_0093;
        #10;
        chk("addi.opcode", 32'(opcode), 32'h13);
        chk("addi.rd",     32'(rd),     32'd1);
        chk("addi.rs1",    32'(rs1),    32'd0);
        chk("addi.funct3", 32'(funct3), 32'd0);
        chk("addi.imm_i",  32'(imm_i),  32'h00A);
        chk_dec("addi", 32'h00A0_0093, 3'd1, 32'h0000_000A, 1'b0);

        chk_dec("beq",    32'hFE00_0EE3, 3'd3, 32'hFFFF_FFFC, 1'b0);
        chk_dec("zero",   32'h0000_0000, 3'd7, 32'h0000_0000, 1'b1);
        chk_dec("lui",    32'h1234_5037, 3'd4, 32'h1234_5000, 1'b0);
        chk_dec("jal",    32'hFF5F_F0EF, 3'd5, 32'hFFFF_FFF4, 1'b0);
        chk_dec("sw",     32'hFE21_AC23, 3'd2, 32'hFFFF_FFF8, 1'b0);
        chk_dec("sub",    32'h4000_0033, 3'd0, 32'h0000_0000, 1'b0);
        chk_dec("mul",    32'h0220_8033, 3'd0, 32'h0000_0000, 1'b1);
        chk_dec("lw",     32'h0000_2003, 3'd1, 32'h0000_0000, 1'b0);
        chk_dec("ld",     32'h0000_3003, 3'd1, 32'h0000_0000, 1'b1);
        chk_dec("srai",   32'h4000_5013, 3'd1, 32'h0000_0400, 1'b0);
        chk_dec("srbad",  32'h2000_5013, 3'd1, 32'h0000_0200, 1'b1);
        chk_dec("jalrf3", 32'h0000_1067, 3'd1, 32'h0000_0000, 1'b1);
        chk_dec("br010",  32'h0000_2063, 3'd3, 32'h0000_0000, 1'b1);

        // Capture stage.
        reset           = 1'b0;
        bus.instr       = 32'h00A0_0093;
        bus.instr_valid = 1'b1;
        tick();
        chk_q("cap_addi", 1'b1, 3'd1, 32'h0000_000A, 5'd1, 5'd0, 5'd10, 1'b0);

        bus.instr       = 32'hFE00_0EE3;
        bus.instr_valid = 1'b0;
        tick();
        chk_q("hold", 1'b0, 3'd1, 32'h0000_000A, 5'd1, 5'd0, 5'd10, 1'b0);
        tick();
        chk_q("hold2", 1'b0, 3'd1, 32'h0000_000A, 5'd1, 5'd0, 5'd10, 1'b0);

        bus.instr_valid = 1'b1;
        tick();
        chk_q("cap_beq", 1'b1, 3'd3, 32'hFFFF_FFFC, 5'd29, 5'd0, 5'd0, 1'b0);

        bus.instr = 32'h0000_0000;
        tick();
        chk_q("cap_zero", 1'b1, 3'd7, 32'h0000_0000, 5'd0, 5'd0, 5'd0, 1'b1);

        bus.instr = 32'hFE21_AC23;
        tick();
        chk_q("cap_sw", 1'b1, 3'd2, 32'hFFFF_FFF8, 5'd24, 5'd3, 5'd2, 1'b0);

        // Reset wins over instr_valid; slices keep tracking.
        reset     = 1'b1;
        bus.instr = 32'h00A0_0093;
        tick();
        chk_q("rst_pri", 1'b0, 3'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("rst_pri.rd",     32'(rd),     32'd1);
        chk("rst_pri.opcode", 32'(opcode), 32'h13);
        chk("rst_pri.fmt",    32'(fmt),    32'd1);
        chk("rst_pri.imm",    imm_ext,     32'h0000_000A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
